// File: rtl/uart_cmd_decoder.sv
// Byte-command register file: 'W' addr data / 'R' addr, one reply byte per command.
// Reply is presented 1 cycle after the final byte and held until tx_ready; bytes arriving mid-reply are dropped with err.
module uart_cmd_decoder #(
    parameter int REG_COUNT      = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [5:0] led,
    output logic       err
);
    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]    REG_LIMIT = 8'(REG_COUNT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    CMD_W     = 8'h57;
    localparam logic [7:0]    CMD_R     = 8'h52;
    localparam logic [7:0]    RSP_OK    = 8'h4B;
    localparam logic [7:0]    RSP_BAD   = 8'h3F;

    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, SEND} state_t;

    state_t        state, state_next;
    logic          op_write, op_write_next;
    logic [AW-1:0] addr;
    logic          addr_ok;
    logic [7:0]    regs [REG_COUNT];
    logic [CW-1:0] cnt, cnt_next;
    logic          addr_load, reg_we, tx_load, err_next;
    logic [7:0]    tx_next;
    logic [AW-1:0] rx_addr;
    logic          rx_addr_ok;

    assign rx_addr    = rx_data[AW-1:0];
    assign rx_addr_ok = rx_data < REG_LIMIT;
    assign tx_valid   = (state == SEND);

    always_comb begin
        state_next    = state;
        op_write_next = op_write;
        cnt_next      = cnt;
        addr_load     = 1'b0;
        reg_we        = 1'b0;
        tx_load       = 1'b0;
        tx_next       = tx_data;
        err_next      = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    cnt_next = '0;
                    if (rx_data == CMD_W || rx_data == CMD_R) begin
                        state_next    = GET_ADDR;
                        op_write_next = (rx_data == CMD_W);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                // An arriving byte takes priority over the timeout on the same cycle.
                if (rx_valid) begin
                    cnt_next  = '0;
                    addr_load = 1'b1;
                    if (op_write) begin
                        state_next = GET_DATA;
                    end else begin
                        state_next = SEND;
                        tx_load    = 1'b1;
                        tx_next    = rx_addr_ok ? regs[rx_addr] : RSP_BAD;
                        err_next   = !rx_addr_ok;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    cnt_next   = '0;
                    state_next = SEND;
                    reg_we     = addr_ok;
                    tx_load    = 1'b1;
                    tx_next    = addr_ok ? RSP_OK : RSP_BAD;
                    err_next   = !addr_ok;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            SEND: begin
                err_next = rx_valid;
                if (tx_ready) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_write <= 1'b0;
            addr     <= '0;
            addr_ok  <= 1'b0;
            cnt      <= '0;
            tx_data  <= '0;
            err      <= 1'b0;
            led      <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state    <= state_next;
            op_write <= op_write_next;
            cnt      <= cnt_next;
            err      <= err_next;
            led      <= regs[0][5:0];
            if (addr_load) begin
                addr    <= rx_addr;
                addr_ok <= rx_addr_ok;
            end
            if (tx_load) begin
                tx_data <= tx_next;
            end
            if (reg_we) begin
                regs[addr] <= rx_data;
            end
        end
    end
endmodule
